// File: rtl/imag_pkg.sv
// Shared types for the image test-pattern generator: FSM state encoding and
// the pattern mode codes.
package imag_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_HGAP   = 2'd3
    } imag_gen_st_t;

    localparam logic [1:0] IMAG_MODE_SOLID = 2'd0;
    localparam logic [1:0] IMAG_MODE_RAMP  = 2'd1;
    localparam logic [1:0] IMAG_MODE_BAR   = 2'd2;
    localparam logic [1:0] IMAG_MODE_CHK   = 2'd3;

endpackage

// File: rtl/imag_pix_calc.sv
// Combinational pixel value for one coordinate: solid fill, horizontal ramp,
// 8 colour bars (channel c follows bar-index bit c mod 3) or checkerboard.
module imag_pix_calc
    import imag_pkg::*;
#(
    parameter int MD_DATA_WDTH = 8,
    parameter int MD_CHN_NUM   = 3,
    parameter int MD_SIZE_WDTH = 12,
    parameter int MD_CHK_LOG   = 3
) (
    input  logic [1:0]                         mode,
    input  logic [MD_SIZE_WDTH-1:0]            x,
    input  logic [MD_SIZE_WDTH-1:0]            y,
    input  logic [MD_SIZE_WDTH-1:0]            ofs,
    input  logic [2:0]                         bar_idx,
    input  logic [MD_CHN_NUM*MD_DATA_WDTH-1:0] solid,
    output logic [MD_CHN_NUM*MD_DATA_WDTH-1:0] pix
);

    logic [MD_SIZE_WDTH-1:0]              ramp_x;
    logic [MD_SIZE_WDTH+MD_DATA_WDTH-1:0] ramp_wide;
    logic [MD_SIZE_WDTH-1:0]              cell_x;
    logic [MD_SIZE_WDTH-1:0]              cell_y;
    logic                                 chk_on;

    assign ramp_x    = x + ofs;
    // Zero-extend first so the low slice is valid for any channel width.
    assign ramp_wide = {{MD_DATA_WDTH{1'b0}}, ramp_x};
    assign cell_x    = x >> MD_CHK_LOG;
    assign cell_y    = y >> MD_CHK_LOG;
    assign chk_on    = cell_x[0] ^ cell_y[0];

    for (genvar c = 0; c < MD_CHN_NUM; c++) begin : g_chn
        localparam int SEL = c % 3;
        logic [MD_DATA_WDTH-1:0] chn;

        always_comb begin
            chn = '0;
            case (mode)
                IMAG_MODE_SOLID: chn = solid[c*MD_DATA_WDTH +: MD_DATA_WDTH];
                IMAG_MODE_RAMP:  chn = ramp_wide[MD_DATA_WDTH-1:0];
                IMAG_MODE_BAR:   chn = {MD_DATA_WDTH{bar_idx[SEL]}};
                default:         chn = {MD_DATA_WDTH{chk_on}};
            endcase
        end

        assign pix[c*MD_DATA_WDTH +: MD_DATA_WDTH] = chn;
    end

endmodule

// File: rtl/imag_pattern_gen.sv
// Test-pattern generator with an AXI-Stream master output. Defining
// IMAG_PATTERN_GEN_FRM_CNT_EN adds o_frm_cnt and makes the ramp move per frame.
module imag_pattern_gen
    import imag_pkg::*;
#(
    parameter int MD_DATA_WDTH = 8,
    parameter int MD_CHN_NUM   = 3,
    parameter int MD_SIZE_WDTH = 12,
    parameter int MD_HBLANK    = 4,
    parameter int MD_CHK_LOG   = 3
) (
    input  logic                               i_sys_clk,
    input  logic                               i_sys_resetn,
    input  logic                               i_start,
    input  logic [1:0]                         i_mode,
    input  logic [MD_SIZE_WDTH-1:0]            i_img_w,
    input  logic [MD_SIZE_WDTH-1:0]            i_img_h,
    input  logic [MD_SIZE_WDTH-1:0]            i_frm_num,
    input  logic [MD_CHN_NUM*MD_DATA_WDTH-1:0] i_solid,
    input  logic                               i_stop,
    output logic [MD_CHN_NUM*MD_DATA_WDTH-1:0] m_axis_tdata,
    output logic                               m_axis_tvalid,
    output logic                               m_axis_tuser,
    output logic                               m_axis_tlast,
    input  logic                               m_axis_tready,
`ifdef IMAG_PATTERN_GEN_FRM_CNT_EN
    output logic [MD_SIZE_WDTH-1:0]            o_frm_cnt,
`endif
    output logic                               o_busy
);

    localparam int SW = MD_SIZE_WDTH;
    localparam int TW = MD_CHN_NUM * MD_DATA_WDTH;
    localparam logic [SW-1:0] ONE      = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [15:0]   GAP_LAST = 16'((MD_HBLANK > 0) ? MD_HBLANK - 1 : 0);

    imag_gen_st_t   state;
    logic [1:0]     mode_r;
    logic [SW-1:0]  w_r, h_r, frm_num_r;
    logic [TW-1:0]  solid_r;
    logic [SW-1:0]  x, y, bar_cnt, frm_cnt;
    logic [2:0]     bar_idx;
    logic           stop_flag;
    logic [15:0]    gap_cnt;

    logic [SW-1:0]  bar_w, last_x;
    logic           line_end, frame_end, run_done, beat, in_load;
    logic [SW-1:0]  nx, ny, nbc, nfrm;
    logic [2:0]     nbi;
    logic [SW-1:0]  px, py, ofs;
    logic [2:0]     pbi;
    logic [TW-1:0]  pix;
    logic           p_user, p_last;

    // Bar width is w/8 with a floor of one pixel, so no divider is needed.
    assign bar_w     = (w_r[SW-1:3] == '0) ? ONE : (w_r >> 3);
    assign last_x    = w_r - ONE;
    assign line_end  = (x == last_x);
    assign frame_end = line_end && (y == h_r - ONE);
    assign beat      = m_axis_tvalid && m_axis_tready;
    assign run_done  = stop_flag || ((frm_num_r != '0) && (nfrm == frm_num_r));
    assign in_load   = (state == ST_LOAD);
    assign o_busy    = (state != ST_IDLE);

    always_comb begin
        nx   = x + ONE;
        ny   = y;
        nbc  = bar_cnt + ONE;
        nbi  = bar_idx;
        nfrm = frm_cnt;
        if (bar_cnt == bar_w - ONE) begin
            nbc = '0;
            if (bar_idx != 3'd7) nbi = bar_idx + 3'd1;
        end
        if (line_end) begin
            nx  = '0;
            nbc = '0;
            nbi = '0;
            ny  = frame_end ? '0 : y + ONE;
            if (frame_end) nfrm = frm_cnt + ONE;
        end
    end

    // In LOAD the counters already hold the first pixel; afterwards the
    // output register is always loaded with the pixel following the one accepted.
    assign px     = in_load ? x : nx;
    assign py     = in_load ? y : ny;
    assign pbi    = in_load ? bar_idx : nbi;
    assign p_user = (px == '0) && (py == '0);
    assign p_last = (px == last_x);

`ifdef IMAG_PATTERN_GEN_FRM_CNT_EN
    assign ofs       = in_load ? frm_cnt : nfrm;
    assign o_frm_cnt = frm_cnt;
`else
    assign ofs = '0;
`endif

    imag_pix_calc #(
        .MD_DATA_WDTH (MD_DATA_WDTH),
        .MD_CHN_NUM   (MD_CHN_NUM),
        .MD_SIZE_WDTH (MD_SIZE_WDTH),
        .MD_CHK_LOG   (MD_CHK_LOG)
    ) u_pix_calc (
        .mode    (mode_r),
        .x       (px),
        .y       (py),
        .ofs     (ofs),
        .bar_idx (pbi),
        .solid   (solid_r),
        .pix     (pix)
    );

    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state         <= ST_IDLE;
            mode_r        <= '0;
            w_r           <= '0;
            h_r           <= '0;
            frm_num_r     <= '0;
            solid_r       <= '0;
            x             <= '0;
            y             <= '0;
            bar_cnt       <= '0;
            bar_idx       <= '0;
            frm_cnt       <= '0;
            stop_flag     <= 1'b0;
            gap_cnt       <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tuser  <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            if (state != ST_IDLE && i_stop) stop_flag <= 1'b1;
            case (state)
                ST_IDLE: begin
                    m_axis_tvalid <= 1'b0;
                    if (i_start && i_img_w != '0 && i_img_h != '0) begin
                        state     <= ST_LOAD;
                        mode_r    <= i_mode;
                        w_r       <= i_img_w;
                        h_r       <= i_img_h;
                        frm_num_r <= i_frm_num;
                        solid_r   <= i_solid;
                        x         <= '0;
                        y         <= '0;
                        bar_cnt   <= '0;
                        bar_idx   <= '0;
                        frm_cnt   <= '0;
                    end
                end
                ST_LOAD: begin
                    state         <= ST_ACTIVE;
                    m_axis_tvalid <= 1'b1;
                    m_axis_tdata  <= pix;
                    m_axis_tuser  <= p_user;
                    m_axis_tlast  <= p_last;
                end
                ST_ACTIVE: begin
                    if (beat) begin
                        x            <= nx;
                        y            <= ny;
                        bar_cnt      <= nbc;
                        bar_idx      <= nbi;
                        frm_cnt      <= nfrm;
                        m_axis_tdata <= pix;
                        m_axis_tuser <= p_user;
                        m_axis_tlast <= p_last;
                        if (frame_end && run_done) begin
                            state         <= ST_IDLE;
                            stop_flag     <= 1'b0;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tdata  <= '0;
                            m_axis_tuser  <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                        end else if (line_end && MD_HBLANK != 0) begin
                            state         <= ST_HGAP;
                            gap_cnt       <= '0;
                            m_axis_tvalid <= 1'b0;
                        end
                    end
                end
                ST_HGAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state         <= ST_ACTIVE;
                        m_axis_tvalid <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
